fc_writeback: RTL

Write-side companion to the fully-connected layer's read scheduler. It takes the MAC pipeline's aligned product stream and produces memory writes. In forward mode it accumulates FAN_IN products plus bias per neuron and writes each saturated activation to the output buffer. In backward mode it applies SGD weight updates to the two weight-memory halves at head/mid addresses that mirror the read side.

---
 rtl/fc_writeback_if.sv | 42 ++++
 rtl/fc_writeback.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/fc_writeback_if.sv
// Beat/write bundle between the MAC pipeline, fc_writeback and the memories.
// The slave modport is the writeback view; master drives beats and sees writes.
interface fc_writeback_if #(
  parameter int ADDR     = 10,
  parameter int OUT_ADDR = 7,
  parameter int DATA_W   = 16,
  parameter int ACC_W    = 40
);
  logic                valid_i;
  logic [ACC_W-1:0]    prod_i;
  logic                has_bias_i;
  logic [DATA_W-1:0]   bias_i;
  logic [DATA_W-1:0]   w_a_i;
  logic [DATA_W-1:0]   w_b_i;
  logic [DATA_W-1:0]   grad_a_i;
  logic [DATA_W-1:0]   grad_b_i;
  logic                out_we;
  logic [OUT_ADDR-1:0] out_addr;
  logic [DATA_W-1:0]   out_data;
  logic                wgt_we;
  logic [ADDR-1:0]     wgt_addr_a;
  logic [ADDR-1:0]     wgt_addr_b;
  logic [DATA_W-1:0]   wgt_data_a;
  logic [DATA_W-1:0]   wgt_data_b;
  logic                done;

  modport slave (
    input  valid_i, prod_i, has_bias_i, bias_i,
    input  w_a_i, w_b_i, grad_a_i, grad_b_i,
    output out_we, out_addr, out_data,
    output wgt_we, wgt_addr_a, wgt_addr_b,
    output wgt_data_a, wgt_data_b, done
  );

  modport master (
    output valid_i, prod_i, has_bias_i, bias_i,
    output w_a_i, w_b_i, grad_a_i, grad_b_i,
    input  out_we, out_addr, out_data,
    input  wgt_we, wgt_addr_a, wgt_addr_b,
    input  wgt_data_a, wgt_data_b, done
  );
endinterface

// File: rtl/fc_writeback.sv
// FC layer writeback: forward accumulate/saturate, backward SGD weight update.
// Optional FC_WB_RELU_EN clamps negative forward activations to zero.
module fc_writeback #(
  parameter int ADDR           = 10,
  parameter int OUT_ADDR       = 7,
  parameter int DATA_W         = 16,
  parameter int ACC_W          = 40,
  parameter int FRAC           = 8,
  parameter int FAN_IN         = 64,
  parameter int FAN_OUT        = 100,
  parameter int MID_PTR_OFFSET = 512
) (
  input logic clk,
  input logic rst_n,
  input logic forward,
  fc_writeback_if.slave bus
);
  localparam int PW = (FAN_IN > 1) ? $clog2(FAN_IN) : 1;
  localparam logic signed [ACC_W-1:0] P_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] P_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_FWD, S_BWD} state_t;

  state_t r_state, w_next;

  logic [PW-1:0]           r_prod_cnt;
  logic [OUT_ADDR-1:0]     r_neuron_cnt;
  logic [ADDR-1:0]         r_head_cnt;
  logic signed [ACC_W-1:0] r_acc;
  logic                    r_seen;
  logic                    r_prev_fwd;
  logic                    r_out_we;
  logic [OUT_ADDR-1:0]     r_out_addr;
  logic [DATA_W-1:0]       r_out_data;
  logic                    r_wgt_we;
  logic [ADDR-1:0]         r_wgt_addr_a;
  logic [ADDR-1:0]         r_wgt_addr_b;
  logic [DATA_W-1:0]       r_wgt_data_a;
  logic [DATA_W-1:0]       r_wgt_data_b;
  logic                    r_done;

  logic                    w_switch;
  logic                    w_fwd_beat;
  logic                    w_bwd_beat;
  logic                    w_last_prod;
  logic                    w_last_neu;
  logic                    w_last_head;
  logic signed [ACC_W-1:0] w_bias_sh;
  logic signed [ACC_W-1:0] w_acc_base;
  logic signed [ACC_W-1:0] w_acc_sum;
  logic signed [ACC_W-1:0] w_shift;
  logic [DATA_W-1:0]       w_act;
  logic [DATA_W-1:0]       w_out;

  function automatic logic [DATA_W-1:0] sat_sub(
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    logic [DATA_W:0] d;
    d = {a[DATA_W-1], a} - {b[DATA_W-1], b};
    if (d[DATA_W] != d[DATA_W-1])
      return d[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}}
                       : {1'b0, {(DATA_W-1){1'b1}}};
    return d[DATA_W-1:0];
  endfunction

  // First cycle after reset has no previous mode to compare against
  assign w_switch    = r_seen && (forward != r_prev_fwd);
  assign w_last_prod = r_prod_cnt == PW'(FAN_IN - 1);
  assign w_last_neu  = r_neuron_cnt == OUT_ADDR'(FAN_OUT - 1);
  assign w_last_head = r_head_cnt == ADDR'(MID_PTR_OFFSET - 1);

  always_comb begin
    w_next     = r_state;
    w_fwd_beat = 1'b0;
    w_bwd_beat = 1'b0;
    if (w_switch) begin
      w_next = S_IDLE;
    end else if (bus.valid_i) begin
      unique case (r_state)
        S_IDLE: begin
          w_fwd_beat = forward;
          w_bwd_beat = !forward;
        end
        S_FWD:   w_fwd_beat = 1'b1;
        S_BWD:   w_bwd_beat = 1'b1;
        default: w_next = S_IDLE;
      endcase
      if (w_fwd_beat)
        w_next = (w_last_prod && w_last_neu) ? S_IDLE : S_FWD;
      if (w_bwd_beat)
        w_next = w_last_head ? S_IDLE : S_BWD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  assign w_bias_sh  = ACC_W'($signed(bus.bias_i)) <<< FRAC;
  assign w_acc_base = (r_prod_cnt != '0) ? r_acc :
                      bus.has_bias_i ? w_bias_sh : '0;
  assign w_acc_sum  = w_acc_base + $signed(bus.prod_i);
  assign w_shift    = w_acc_sum >>> FRAC;

  always_comb begin
    w_act = w_shift[DATA_W-1:0];
    if (w_shift > P_MAX)
      w_act = {1'b0, {(DATA_W-1){1'b1}}};
    else if (w_shift < P_MIN)
      w_act = {1'b1, {(DATA_W-1){1'b0}}};
  end

`ifdef FC_WB_RELU_EN
  assign w_out = w_act[DATA_W-1] ? '0 : w_act;
`else
  assign w_out = w_act;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prod_cnt   <= '0;
      r_neuron_cnt <= '0;
      r_head_cnt   <= '0;
      r_acc        <= '0;
      r_seen       <= 1'b0;
      r_prev_fwd   <= 1'b0;
      r_out_we     <= 1'b0;
      r_out_addr   <= '0;
      r_out_data   <= '0;
      r_wgt_we     <= 1'b0;
      r_wgt_addr_a <= '0;
      r_wgt_addr_b <= '0;
      r_wgt_data_a <= '0;
      r_wgt_data_b <= '0;
      r_done       <= 1'b0;
    end else begin
      r_out_we   <= 1'b0;
      r_wgt_we   <= 1'b0;
      r_done     <= 1'b0;
      r_seen     <= 1'b1;
      r_prev_fwd <= forward;
      if (w_switch) begin
        r_prod_cnt   <= '0;
        r_neuron_cnt <= '0;
        r_head_cnt   <= '0;
        r_acc        <= '0;
      end else if (w_fwd_beat) begin
        r_acc <= w_acc_sum;
        if (w_last_prod) begin
          r_prod_cnt <= '0;
          r_out_we   <= 1'b1;
          r_out_addr <= r_neuron_cnt;
          r_out_data <= w_out;
          if (w_last_neu) begin
            r_neuron_cnt <= '0;
            r_done       <= 1'b1;
          end else begin
            r_neuron_cnt <= r_neuron_cnt + OUT_ADDR'(1);
          end
        end else begin
          r_prod_cnt <= r_prod_cnt + PW'(1);
        end
      end else if (w_bwd_beat) begin
        r_wgt_we     <= 1'b1;
        r_wgt_addr_a <= r_head_cnt;
        r_wgt_addr_b <= ADDR'(MID_PTR_OFFSET) + r_head_cnt;
        r_wgt_data_a <= sat_sub(bus.w_a_i, bus.grad_a_i);
        r_wgt_data_b <= sat_sub(bus.w_b_i, bus.grad_b_i);
        if (w_last_head) begin
          r_head_cnt <= '0;
          r_done     <= 1'b1;
        end else begin
          r_head_cnt <= r_head_cnt + ADDR'(1);
        end
      end
    end
  end

  assign bus.out_we     = r_out_we;
  assign bus.out_addr   = r_out_addr;
  assign bus.out_data   = r_out_data;
  assign bus.wgt_we     = r_wgt_we;
  assign bus.wgt_addr_a = r_wgt_addr_a;
  assign bus.wgt_addr_b = r_wgt_addr_b;
  assign bus.wgt_data_a = r_wgt_data_a;
  assign bus.wgt_data_b = r_wgt_data_b;
  assign bus.done       = r_done;
endmodule
